// File: rtl/mult_arb_pkg.sv
// Shared constants, FSM state type and operand-slice helper for mult_share_arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_arb_pkg;

    localparam int OP_W    = 4;
    localparam int PROD_W  = 8;
    localparam int MAX_REQ = 8;

    // Operand vectors are zero-extended to the widest legal requester count
    // so a single helper serves every N_REQ.
    typedef logic [MAX_REQ*OP_W-1:0] op_vec_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Extract the 4-bit operand of requester idx; base is idx*4, built by concatenation.
    function automatic logic [OP_W-1:0] op_slice(input op_vec_t vec, input logic [2:0] idx);
        logic [4:0] base;
        base = {idx, 2'b00};
        return vec[base +: OP_W];
    endfunction

endpackage

// File: rtl/multiplier_4bit.sv
// Combinational 4x4 unsigned multiplier producing the full 8-bit product.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module multiplier_4bit
    import mult_arb_pkg::*;
(
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic [PROD_W-1:0] product_o
);

    // Zero-extend both operands so no product bit is lost.
    assign product_o = {4'b0000, a_i} * {4'b0000, b_i};

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: en_i low forces grant/any to zero.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    int              pos;
    logic [ID_W-1:0] pos_idx;

    // Scan ptr, ptr+1, ... modulo N_REQ and latch onto the first valid request.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            pos_idx = ID_W'(pos);
            if (en_i && !any_o && req_i[pos_idx]) begin
                any_o          = 1'b1;
                gnt_o[pos_idx] = 1'b1;
                idx_o          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin share of one 4x4 multiplier among N_REQ requesters, product held in a tagged output register.
// Latency: accept in cycle T -> resp_valid/resp_id/resp_product visible in cycle T+1; one result per cycle.
// Backpressure: resp_valid & !resp_ready holds the response and forces req_ready to zero.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [OP_W*N_REQ-1:0] req_a,
    input  logic [OP_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  resp_valid,
    output logic [ID_W-1:0]       resp_id,
    output logic [PROD_W-1:0]     resp_product,
    input  logic                  resp_ready
);

    state_e            state_q;
    logic [ID_W-1:0]   id_q;
    logic [PROD_W-1:0] prod_q;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   ptr_d;

    logic              slot_free;
    logic              pick_en;
    logic              accept;
    logic [ID_W-1:0]   pick_idx;
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic [PROD_W-1:0] mul_p;

    // The slot is free when empty or when the current response leaves this edge.
    // Reset also blocks grants so nothing is accepted while rst is high.
    assign slot_free = (state_q == ST_EMPTY) || resp_ready;
    assign pick_en   = slot_free && !rst;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (pick_en),
        .gnt_o (req_ready),
        .idx_o (pick_idx),
        .any_o (accept)
    );

    // The winner's index steers the operand mux into the single multiplier.
    assign op_a = op_slice(op_vec_t'(req_a), 3'(pick_idx));
    assign op_b = op_slice(op_vec_t'(req_b), 3'(pick_idx));

    multiplier_4bit u_mul (
        .a_i       (op_a),
        .b_i       (op_b),
        .product_o (mul_p)
    );

    // Priority moves to the requester just after the winner.
    always_comb begin
        ptr_d = pick_idx + 1'b1;
        if (pick_idx == ID_W'(N_REQ - 1)) begin
            ptr_d = '0;
        end
    end

    // EMPTY/FULL output register: load on accept, drain on ready without accept, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            id_q    <= '0;
            prod_q  <= '0;
            ptr_q   <= '0;
        end else if (accept) begin
            state_q <= ST_FULL;
            id_q    <= pick_idx;
            prod_q  <= mul_p;
            ptr_q   <= ptr_d;
        end else if (state_q == ST_FULL && resp_ready) begin
            state_q <= ST_EMPTY;
        end
    end

    assign resp_valid   = (state_q == ST_FULL);
    assign resp_id      = id_q;
    assign resp_product = prod_q;

endmodule
